// File: rtl/csr_pkg.sv
// CSR access unit shared types: funct3 opcodes, CSR address map, lookup
// helpers and FSM state encoding.
package csr_pkg;

   localparam int unsigned CSR_ADDR_W = 12;
   localparam int unsigned CSR_IDX_W  = 5;
   localparam int unsigned RS1_W      = 5;

   // Zicsr funct3 encodings; 000 and 100 are unused.
   typedef enum logic [2:0] {
      CSR_OP_RW  = 3'b001,
      CSR_OP_RS  = 3'b010,
      CSR_OP_RC  = 3'b011,
      CSR_OP_RWI = 3'b101,
      CSR_OP_RSI = 3'b110,
      CSR_OP_RCI = 3'b111
   } csr_op_e;

   localparam logic [CSR_ADDR_W-1:0] CSR_MSTATUS  = 12'h300;
   localparam logic [CSR_ADDR_W-1:0] CSR_MISA     = 12'h301;
   localparam logic [CSR_ADDR_W-1:0] CSR_MIE      = 12'h304;
   localparam logic [CSR_ADDR_W-1:0] CSR_MTVEC    = 12'h305;
   localparam logic [CSR_ADDR_W-1:0] CSR_MSCRATCH = 12'h340;
   localparam logic [CSR_ADDR_W-1:0] CSR_MEPC     = 12'h341;
   localparam logic [CSR_ADDR_W-1:0] CSR_MCAUSE   = 12'h342;
   localparam logic [CSR_ADDR_W-1:0] CSR_MTVAL    = 12'h343;

   typedef struct packed {
      logic                 valid;
      logic                 ro;
      logic [CSR_IDX_W-1:0] idx;
   } csr_lookup_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_MODIFY,
      S_WRITE,
      S_RESP
   } csr_state_e;

   // Map a CSR address to its register-file slot.
   function automatic csr_lookup_t csr_lookup(input logic [CSR_ADDR_W-1:0] addr);
      csr_lookup_t r;
      r       = '0;
      r.valid = 1'b1;
      case (addr)
         CSR_MSTATUS:  r.idx = 5'd0;
         CSR_MISA:     begin r.idx = 5'd1; r.ro = 1'b1; end
         CSR_MIE:      r.idx = 5'd2;
         CSR_MTVEC:    r.idx = 5'd3;
         CSR_MSCRATCH: r.idx = 5'd4;
         CSR_MEPC:     r.idx = 5'd5;
         CSR_MCAUSE:   r.idx = 5'd6;
         CSR_MTVAL:    r.idx = 5'd7;
         default:      r.valid = 1'b0;
      endcase
      return r;
   endfunction

   // funct3 values with a defined Zicsr meaning.
   function automatic logic csr_f3_legal(input logic [2:0] f3);
      return f3[1:0] != 2'b00;
   endfunction

   // True when the instruction intends to modify the CSR.
   function automatic logic csr_f3_writes(input logic [2:0] f3, input logic [RS1_W-1:0] rs1);
      return (f3[1:0] == 2'b01) || (rs1 != '0);
   endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Read-modify-write datapath: new CSR value and write suppression for
// set/clear forms with rs1/zimm equal to zero.
module csr_rmw_alu
   import csr_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [2:0]       op_i,
   input  logic [XLEN-1:0]  old_i,
   input  logic [XLEN-1:0]  operand_i,
   input  logic [RS1_W-1:0] rs1_idx_i,
   output logic [XLEN-1:0]  new_val_c_o,
   output logic             suppress_c_o
);

   // Combine old value and operand according to the Zicsr operation.
   always_comb begin
      new_val_c_o  = old_i;
      suppress_c_o = 1'b0;
      case (op_i)
         CSR_OP_RW, CSR_OP_RWI: new_val_c_o = operand_i;
         CSR_OP_RS, CSR_OP_RSI: begin
            new_val_c_o  = old_i | operand_i;
            suppress_c_o = (rs1_idx_i == '0);
         end
         CSR_OP_RC, CSR_OP_RCI: begin
            new_val_c_o  = old_i & ~operand_i;
            suppress_c_o = (rs1_idx_i == '0);
         end
         default: suppress_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: sequences one Zicsr instruction through the CSR file
// read/write port (IDLE -> READ -> MODIFY -> WRITE -> RESP).
// Optional feature macro: CSR_ILLEGAL_TRAP_EN (report illegal accesses).
module csr_access_unit
   import csr_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned IDX_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic [11:0]      req_addr,
   input  logic [XLEN-1:0]  req_rs1_data,
   input  logic [4:0]       req_rs1_idx,
   input  logic             flush,
   output logic [IDX_W-1:0] csr_idx,
   output logic             csr_re,
   input  logic [XLEN-1:0]  csr_rdata,
   output logic             csr_we,
   output logic [XLEN-1:0]  csr_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_data,
   output logic             resp_illegal
);

   csr_state_e        state_q;
   logic              req_ready_q, csr_re_q, csr_we_q, resp_valid_q, resp_illegal_q;
   logic              ro_q;
   logic [IDX_W-1:0]  csr_idx_q;
   logic [XLEN-1:0]   csr_wdata_q, resp_data_q, operand_q;
   logic [2:0]        op_q;
   logic [RS1_W-1:0]  rs1_idx_q;

   csr_lookup_t       lk_c;
   logic              illegal_c, skip_c;
   logic [XLEN-1:0]   alu_new_c;
   logic              alu_sup_c;

   // Decode the offered request: address map, legality and CSR-access skip.
   always_comb begin
      lk_c      = '0;
      illegal_c = 1'b0;
      skip_c    = 1'b0;
      lk_c      = csr_lookup(req_addr);
`ifdef CSR_ILLEGAL_TRAP_EN
      illegal_c = !lk_c.valid || !csr_f3_legal(req_funct3) ||
                  (lk_c.ro && csr_f3_writes(req_funct3, req_rs1_idx));
      skip_c    = illegal_c;
`else
      skip_c    = !lk_c.valid || !csr_f3_legal(req_funct3);
`endif
   end

   csr_rmw_alu #(.XLEN(XLEN)) u_alu (
      .op_i         (op_q),
      .old_i        (csr_rdata),
      .operand_i    (operand_q),
      .rs1_idx_i    (rs1_idx_q),
      .new_val_c_o  (alu_new_c),
      .suppress_c_o (alu_sup_c)
   );

   // Sequencer with registered port outputs; strobes default low each cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         req_ready_q    <= 1'b1;
         csr_re_q       <= 1'b0;
         csr_we_q       <= 1'b0;
         csr_idx_q      <= '0;
         csr_wdata_q    <= '0;
         resp_valid_q   <= 1'b0;
         resp_data_q    <= '0;
         resp_illegal_q <= 1'b0;
         ro_q           <= 1'b0;
         operand_q      <= '0;
         op_q           <= '0;
         rs1_idx_q      <= '0;
      end else begin
         csr_re_q <= 1'b0;
         csr_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q        <= req_funct3;
                  rs1_idx_q   <= req_rs1_idx;
                  operand_q   <= req_funct3[2] ? XLEN'(req_rs1_idx) : req_rs1_data;
                  ro_q        <= lk_c.ro;
                  req_ready_q <= 1'b0;
                  resp_data_q <= '0;
                  if (skip_c) begin
                     state_q        <= S_RESP;
                     resp_valid_q   <= 1'b1;
                     resp_illegal_q <= illegal_c;
                  end else begin
                     state_q   <= S_READ;
                     csr_re_q  <= 1'b1;
                     csr_idx_q <= IDX_W'(lk_c.idx);
                  end
               end
            end
            S_READ: begin
               if (flush) begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else begin
                  state_q <= S_MODIFY;
               end
            end
            S_MODIFY: begin
               if (flush) begin
                  state_q     <= S_IDLE;
                  req_ready_q <= 1'b1;
               end else begin
                  state_q     <= S_WRITE;
                  resp_data_q <= csr_rdata;
                  csr_wdata_q <= alu_new_c;
                  csr_we_q    <= !alu_sup_c && !ro_q;
               end
            end
            S_WRITE: begin
               state_q        <= S_RESP;
               resp_valid_q   <= 1'b1;
               resp_illegal_q <= 1'b0;
            end
            S_RESP: begin
               if (resp_ready) begin
                  state_q        <= S_IDLE;
                  resp_valid_q   <= 1'b0;
                  resp_illegal_q <= 1'b0;
                  req_ready_q    <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign csr_re       = csr_re_q;
   assign csr_we       = csr_we_q;
   assign csr_idx      = csr_idx_q;
   assign csr_wdata    = csr_wdata_q;
   assign resp_valid   = resp_valid_q;
   assign resp_data    = resp_data_q;
   assign resp_illegal = resp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: CSR file model, reference model of the
// architectural CSR state, and a response scoreboard.
module tb_csr_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [2:0]  req_funct3;
   logic [11:0] req_addr;
   logic [31:0] req_rs1_data;
   logic [4:0]  req_rs1_idx;
   logic        flush;
   logic [4:0]  csr_idx;
   logic        csr_re, csr_we;
   logic [31:0] csr_rdata, csr_wdata;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic        resp_illegal;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic        illegal;
   } exp_t;
   exp_t exp_q[$];

   logic [31:0] file_mem [32];
   logic [31:0] ref_mem  [8];
   logic        prev_re = 1'b0, prev_we = 1'b0;

   logic [11:0] addr_tab [11] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h7C0, 12'hF14, 12'h000};

   always #5 clk = ~clk;

   csr_access_unit #(.XLEN(32), .IDX_W(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_rs1_data (req_rs1_data),
      .req_rs1_idx  (req_rs1_idx),
      .flush        (flush),
      .csr_idx      (csr_idx),
      .csr_re       (csr_re),
      .csr_rdata    (csr_rdata),
      .csr_we       (csr_we),
      .csr_wdata    (csr_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_data    (resp_data),
      .resp_illegal (resp_illegal)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int ref_idx(input logic [11:0] a);
      case (a)
         12'h300: return 0;
         12'h301: return 1;
         12'h304: return 2;
         12'h305: return 3;
         12'h340: return 4;
         12'h341: return 5;
         12'h342: return 6;
         12'h343: return 7;
         default: return -1;
      endcase
   endfunction

   // CSR register file: read data one cycle after the strobe; strobe protocol checks.
   always @(posedge clk) begin
      if (csr_re || csr_we) begin
         check("re_we_exclusive", 32'(csr_re && csr_we), 32'd0);
         check("re_one_cycle", 32'(csr_re && prev_re), 32'd0);
         check("we_one_cycle", 32'(csr_we && prev_we), 32'd0);
      end
      prev_re = csr_re;
      prev_we = csr_we;
      if (csr_re) csr_rdata <= file_mem[csr_idx];
      if (csr_we) file_mem[csr_idx] = csr_wdata;
   end

   // Response monitor: pops the scoreboard on each handshake, checks hold stability.
   exp_t        mon_e;
   logic [31:0] held_data;
   logic        held_ill;
   bit          held = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else if (resp_valid) begin
         if (held) begin
            check("resp_stable_data", resp_data, held_data);
            check("resp_stable_illegal", 32'(resp_illegal), 32'(held_ill));
         end
         if (resp_ready) begin
            if (exp_q.size() == 0) begin
               check("resp_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = exp_q.pop_front();
               check("resp_data", resp_data, mon_e.data);
               check("resp_illegal", 32'(resp_illegal), 32'(mon_e.illegal));
            end
            held = 1'b0;
         end else begin
            held      = 1'b1;
            held_data = resp_data;
            held_ill  = resp_illegal;
         end
      end else begin
         held = 1'b0;
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      check({tag, "_csr_re"}, 32'(csr_re), 32'd0);
      check({tag, "_csr_we"}, 32'(csr_we), 32'd0);
      check({tag, "_csr_idx"}, 32'(csr_idx), 32'd0);
      check({tag, "_csr_wdata"}, csr_wdata, 32'd0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_resp_data"}, resp_data, 32'd0);
      check({tag, "_resp_illegal"}, 32'(resp_illegal), 32'd0);
   endtask

   // Issue one instruction. flush_at: 0 none, 1 READ, 2 MODIFY, 3 WRITE.
   // hold: cycles resp_ready stays low (-1 = random). rst_mid: reset during WRITE.
   task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1d,
                        input logic [4:0] rs1i, input int flush_at, input int hold, input bit rst_mid);
      int          idx, guard, cnt;
      bit          mapped, ro, f3ok, writes, illegal, skip, do_we, killed, done;
      logic [31:0] opnd, old, nv;

      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);

      idx    = ref_idx(addr);
      mapped = (idx >= 0);
      ro     = (addr == 12'h301);
      f3ok   = f3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
      writes = (f3[1:0] == 2'b01) || (rs1i != 5'd0);
      opnd   = f3[2] ? {27'd0, rs1i} : rs1d;
`ifdef CSR_ILLEGAL_TRAP_EN
      illegal = !mapped || !f3ok || (ro && writes);
      skip    = illegal;
`else
      illegal = 1'b0;
      skip    = !mapped || !f3ok;
`endif
      old = 32'd0;
      if (!skip) old = ref_mem[idx];
      case (f3[1:0])
         2'b01:   nv = opnd;
         2'b10:   nv = old | opnd;
         default: nv = old & ~opnd;
      endcase
      do_we  = !skip && writes && !ro;
      killed = (!skip && (flush_at == 1 || flush_at == 2)) || rst_mid;
      if (!killed) begin
         exp_q.push_back('{old, illegal});
         if (do_we) ref_mem[idx] = nv;
      end

      req_funct3   = f3;
      req_addr     = addr;
      req_rs1_data = rs1d;
      req_rs1_idx  = rs1i;
      req_valid    = 1'b1;
      @(posedge clk); #1;                 // T1
      req_valid    = 1'b0;
      req_funct3   = 3'($urandom);
      req_addr     = 12'($urandom);
      req_rs1_data = $urandom;
      req_rs1_idx  = 5'($urandom);
      check("req_ready_busy", 32'(req_ready), 32'd0);

      if (skip) begin
         check("skip_no_re_T1", 32'(csr_re), 32'd0);
         check("skip_resp_valid_T1", 32'(resp_valid), 32'd1);
      end else begin
         check("re_T1", 32'(csr_re), 32'd1);
         check("idx_T1", 32'(csr_idx), 32'(idx));
         if (flush_at == 1) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check("flush_read_ready", 32'(req_ready), 32'd1);
            check("flush_read_no_resp", 32'(resp_valid), 32'd0);
            return;
         end
         @(posedge clk); #1;              // T2
         check("we_T2_low", 32'(csr_we), 32'd0);
         if (flush_at == 2) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            check("flush_modify_ready", 32'(req_ready), 32'd1);
            check("flush_modify_no_we", 32'(csr_we), 32'd0);
            check("flush_modify_no_resp", 32'(resp_valid), 32'd0);
            return;
         end
         @(posedge clk); #1;              // T3
         check("we_T3", 32'(csr_we), 32'(do_we));
         if (do_we) check("wdata_T3", csr_wdata, nv);
         if (rst_mid) begin
            #1 rst = 1'b1;
            #1;
            check_reset_outputs("rst_mid");
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         if (flush_at == 3) flush = 1'b1;
         @(posedge clk); #1;              // T4
         flush = 1'b0;
         check("resp_valid_T4", 32'(resp_valid), 32'd1);
      end

      cnt  = 0;
      done = 1'b0;
      while (!done && cnt < 64) begin
         if (hold >= 0) resp_ready = (cnt >= hold);
         else           resp_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         done = resp_valid && resp_ready;
         @(posedge clk); #1;
         cnt++;
      end
      resp_ready = 1'b0;
      if (!done) check("resp_timeout", 32'd0, 32'd1);
      check("ready_after_resp", 32'(req_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3;
      logic [4:0]  ri;
      int          r, fa;

      rst          = 1'b1;
      req_valid    = 1'b0;
      req_funct3   = 3'd0;
      req_addr     = 12'd0;
      req_rs1_data = 32'd0;
      req_rs1_idx  = 5'd0;
      flush        = 1'b0;
      resp_ready   = 1'b0;

      for (int i = 0; i < 32; i++) file_mem[i] = $urandom;
      file_mem[0] = 32'h0000_1888;
      file_mem[1] = 32'h4000_1100;
      file_mem[2] = 32'h0000_0008;
      file_mem[4] = 32'h1234_5678;
      for (int i = 0; i < 8; i++) ref_mem[i] = file_mem[i];

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      check("post_reset_ready", 32'(req_ready), 32'd1);

      // Directed cases.
      issue(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd5, 0, 0, 1'b0);   // CSRRW mscratch
      issue(3'b010, 12'h304, 32'h0000_0880, 5'd3, 0, 0, 1'b0);   // CSRRS mie -> 0x888
      issue(3'b011, 12'h304, 32'hFFFF_FFFF, 5'd0, 0, 0, 1'b0);   // CSRRC rs1=x0: read only
      issue(3'b111, 12'h300, 32'h0,         5'd8, 0, 3, 1'b0);   // CSRRCI mstatus, held response
      issue(3'b001, 12'h7C0, 32'h1111_2222, 5'd4, 0, 0, 1'b0);   // unmapped
      issue(3'b001, 12'h301, 32'h5555_AAAA, 5'd4, 0, 0, 1'b0);   // write to misa
      issue(3'b010, 12'h301, 32'h0,         5'd0, 0, 0, 1'b0);   // read misa
      issue(3'b000, 12'h340, 32'h0,         5'd1, 0, 0, 1'b0);   // unused funct3
      issue(3'b001, 12'h341, 32'hAAAA_0001, 5'd2, 2, 0, 1'b0);   // flush in MODIFY
      issue(3'b001, 12'h341, 32'hBBBB_0002, 5'd2, 0, 0, 1'b0);   // back-to-back after flush
      issue(3'b110, 12'h305, 32'h0,         5'd9, 1, 0, 1'b0);   // flush in READ
      issue(3'b001, 12'h342, 32'hCCCC_0003, 5'd2, 3, 1, 1'b0);   // flush in WRITE ignored
      issue(3'b001, 12'h343, 32'hDDDD_0004, 5'd6, 0, 0, 1'b1);   // reset mid-WRITE

      // Randomised traffic.
      for (int n = 0; n < 200; n++) begin
         f3 = 3'($urandom_range(0, 7));
         ri = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
         r  = $urandom_range(0, 9);
         fa = (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 0;
         issue(f3, addr_tab[$urandom_range(0, 10)], $urandom, ri, fa, -1, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 8; i++) check($sformatf("file_mem[%0d]", i), file_mem[i], ref_mem[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
